// File: rtl/tictactoe_pkg.sv
// rtl/tictactoe_pkg.sv - shared constants and types for the tic-tac-toe referee
package tictactoe_pkg;

   localparam int BOARD_W = 9;

   typedef enum logic {
      TURN_X = 1'b0,
      TURN_O = 1'b1
   } turn_t;

   localparam logic [0:2] RES_NONE = 3'b000;
   localparam logic [0:2] RES_X    = 3'b100;
   localparam logic [0:2] RES_O    = 3'b010;
   localparam logic [0:2] RES_DRAW = 3'b001;

   // Cell 0 is the leftmost bit, so masks read row-major left to right.
   localparam logic [0:BOARD_W-1] WIN_LINES [8] = '{
      9'b111000000, 9'b000111000, 9'b000000111,
      9'b100100100, 9'b010010010, 9'b001001001,
      9'b100010001, 9'b001010100
   };

endpackage

// File: rtl/tictactoe_game_win_detect.sv
// rtl/tictactoe_game_win_detect.sv - flags a board holding any complete win line
module win_detect
   import tictactoe_pkg::*;
(
   input  logic [0:BOARD_W-1] board,
   output logic               has_line
);

   always_comb begin
      has_line = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if ((board & WIN_LINES[i]) == WIN_LINES[i]) begin
            has_line = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tictactoe_game.sv
// rtl/tictactoe_game.sv - tic-tac-toe referee: board, turn order and registered result
module tictactoe_game
   import tictactoe_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic [0:BOARD_W-1] posicao,
   output logic [0:2]         vencedor
);

   logic [0:BOARD_W-1] board_x;
   logic [0:BOARD_W-1] board_o;
   logic [0:BOARD_W-1] next_x;
   logic [0:BOARD_W-1] next_o;
   turn_t              turn;
   logic               accept;
   logic               win_x;
   logic               win_o;
   logic [0:2]         next_result;

   assign accept = $onehot(posicao)
                && ((posicao & (board_x | board_o)) == '0)
                && (vencedor == RES_NONE);

   always_comb begin
      next_x = board_x;
      next_o = board_o;
      if (accept) begin
         if (turn == TURN_X) next_x = board_x | posicao;
         else                next_o = board_o | posicao;
      end
   end

   win_detect u_win_x (.board(next_x), .has_line(win_x));
   win_detect u_win_o (.board(next_o), .has_line(win_o));

   // Only the mover can complete a line, and a win beats a full board.
   always_comb begin
      next_result = RES_NONE;
      if ((turn == TURN_X) && win_x)      next_result = RES_X;
      else if ((turn == TURN_O) && win_o) next_result = RES_O;
      else if (&(next_x | next_o))        next_result = RES_DRAW;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         board_x  <= '0;
         board_o  <= '0;
         turn     <= TURN_X;
         vencedor <= RES_NONE;
      end else if (accept) begin
         board_x  <= next_x;
         board_o  <= next_o;
         turn     <= (turn == TURN_X) ? TURN_O : TURN_X;
         vencedor <= next_result;
      end
   end

endmodule

// File: tb/tb_tictactoe_game.sv
// tb/tb_tictactoe_game.sv - table-driven scoreboard bench for tictactoe_game
module tb_tictactoe_game;

   typedef struct {
      logic       rst;
      logic [0:8] pos;
      logic [0:2] exp;
      string      name;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [0:8] posicao = '0;
   logic [0:2] vencedor;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   passed = 0;
   int   total  = 0;

   tictactoe_game dut (
      .clock   (clock),
      .reset   (reset),
      .posicao (posicao),
      .vencedor(vencedor)
   );

   always #5 clock = ~clock;

   function automatic void add(input logic r, input logic [0:8] p, input logic [0:2] e, input string nm);
      vec_t v;
      v.rst = r; v.pos = p; v.exp = e; v.name = nm;
      vecs.push_back(v);
   endfunction

   task automatic step(input logic r, input logic [0:8] p, input logic [0:2] e, input string nm);
      vec_t v;
      vec_t w;
      v.rst = r; v.pos = p; v.exp = e; v.name = nm;
      @(negedge clock);
      reset   = r;
      posicao = p;
      exp_q.push_back(v);
      @(posedge clock);
      #1;
      w = exp_q.pop_front();
      total++;
      if (vencedor === w.exp) passed++;
      else $display("FAIL %s: vencedor=%b required %b", w.name, vencedor, w.exp);
   endtask

   initial begin
      // Reset held 3 cycles with a move present, then X top-row win.
      add(1, 9'b100000000, 3'b000, "reset0");
      add(1, 9'b100000000, 3'b000, "reset1");
      add(1, 9'b100000000, 3'b000, "reset2");
      add(0, 9'b100000000, 3'b000, "xwin_m1");
      add(0, 9'b000100000, 3'b000, "xwin_m2");
      add(0, 9'b010000000, 3'b000, "xwin_m3");
      add(0, 9'b000010000, 3'b000, "xwin_m4");
      add(0, 9'b001000000, 3'b100, "xwin_m5");
      add(0, 9'b000000010, 3'b100, "freeze_a");
      add(0, 9'b000000001, 3'b100, "freeze_b");
      add(1, 9'b000000000, 3'b000, "reset_after_win");
      // O anti-diagonal win; only possible if the board was cleared and X moves first.
      add(0, 9'b100000000, 3'b000, "owin_m1");
      add(0, 9'b001000000, 3'b000, "owin_m2");
      add(0, 9'b010000000, 3'b000, "owin_m3");
      add(0, 9'b000010000, 3'b000, "owin_m4");
      add(0, 9'b000000001, 3'b000, "owin_m5");
      add(0, 9'b000000100, 3'b010, "owin_m6");
      add(1, 9'b000000000, 3'b000, "reset_rej");
      // Rejections, then O at cell 8 and an X row win proves they had no effect.
      add(0, 9'b100000000, 3'b000, "rej_x0");
      add(0, 9'b100000000, 3'b000, "rej_occupied");
      add(0, 9'b110000000, 3'b000, "rej_multihot");
      add(0, 9'b000000000, 3'b000, "rej_zero");
      add(0, 9'b000000001, 3'b000, "rej_o8");
      add(0, 9'b010000000, 3'b000, "rej_x1");
      add(0, 9'b000000010, 3'b000, "rej_o7");
      add(0, 9'b001000000, 3'b100, "rej_x2_win");
      add(1, 9'b000000000, 3'b000, "reset_draw");
      // Draw: X0 O1 X2 O4 X3 O5 X7 O6 X8.
      add(0, 9'b100000000, 3'b000, "draw_1");
      add(0, 9'b010000000, 3'b000, "draw_2");
      add(0, 9'b001000000, 3'b000, "draw_3");
      add(0, 9'b000010000, 3'b000, "draw_4");
      add(0, 9'b000100000, 3'b000, "draw_5");
      add(0, 9'b000001000, 3'b000, "draw_6");
      add(0, 9'b000000010, 3'b000, "draw_7");
      add(0, 9'b000000100, 3'b000, "draw_8");
      add(0, 9'b000000001, 3'b001, "draw_9");
      add(0, 9'b000000000, 3'b001, "draw_hold");
      add(1, 9'b000000000, 3'b000, "reset_win9");
      // X completes column 2 on the ninth move: win, not draw.
      add(0, 9'b100000000, 3'b000, "w9_1");
      add(0, 9'b010000000, 3'b000, "w9_2");
      add(0, 9'b001000000, 3'b000, "w9_3");
      add(0, 9'b000010000, 3'b000, "w9_4");
      add(0, 9'b000001000, 3'b000, "w9_5");
      add(0, 9'b000100000, 3'b000, "w9_6");
      add(0, 9'b000000010, 3'b000, "w9_7");
      add(0, 9'b000000100, 3'b000, "w9_8");
      add(0, 9'b000000001, 3'b100, "w9_9");

      foreach (vecs[i]) step(vecs[i].rst, vecs[i].pos, vecs[i].exp, vecs[i].name);

      // Held move places once: X holds cell 0, then O8, X1, O7, X2 wins for X.
      step(1, 9'b000000000, 3'b000, "hold_reset");
      for (int k = 0; k < 3; k++) step(0, 9'b100000000, 3'b000, "hold_x0");
      step(0, 9'b000000001, 3'b000, "hold_o8");
      step(0, 9'b010000000, 3'b000, "hold_x1");
      step(0, 9'b000000010, 3'b000, "hold_o7");
      step(0, 9'b001000000, 3'b100, "hold_x2_win");

      // Reset with a move on the same edge: reset wins, then X moves first.
      step(1, 9'b000010000, 3'b000, "reset_priority");
      step(0, 9'b000010000, 3'b000, "prio_x4");
      step(0, 9'b100000000, 3'b000, "prio_o0");
      step(0, 9'b000100000, 3'b000, "prio_x3");
      step(0, 9'b010000000, 3'b000, "prio_o1");
      step(0, 9'b000001000, 3'b100, "prio_x5_win");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/tictactoe_game.md
# tictactoe_game

Two-player tic-tac-toe referee core: holds the 3×3 board, alternates turns between X and O, accepts one move per clock and declares X win, O win or draw. It sits between the move-entry logic, which drives `posicao`, and the display/VGA logic, which consumes `vencedor`. All state is in this block and it has no handshake outputs.

## Interface
- Parameters: none.
- `clock` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; clears board, turn and result.
- `posicao` input [0:8]: move request, one-hot.
  - Bit n selects cell n, row-major: `posicao[0]` is top-left, `posicao[8]` is bottom-right.
  - All-zero means no move.
- `vencedor` output [0:2]: registered result.
  - `[0]` = X won, `[1]` = O won, `[2]` = draw.
  - 3'b000 means the game is in progress.
  - At most one bit is set at any time.

## Operation
- State:
  - `board_x[0:8]` and `board_o[0:8]`, cell occupancy per player.
  - `turn`: 0 = X to move, 1 = O to move.
  - `vencedor` register.
- Reset: boards = 0, `turn` = 0 (X moves first), `vencedor` = 000. Reset has priority over any move in the same cycle.
- Move accepted on an edge only if all of the following hold:
  - `posicao` is exactly one-hot.
  - The selected cell is empty in both boards.
  - `vencedor` == 000.
- Accepted move:
  - Sets the selected bit in the current player's board.
  - Toggles `turn`.
  - Updates `vencedor` from the post-move board on the same edge.
- Rejected move has no effect on any state. Rejection cases: all-zero, multi-hot, occupied cell, or game over.
- Holding the same `posicao` for several cycles places the piece once; later cycles are rejected because the cell is occupied.
- Win lines (8):
  - Rows: {0,1,2}, {3,4,5}, {6,7,8}.
  - Columns: {0,3,6}, {1,4,7}, {2,5,8}.
  - Diagonals: {0,4,8}, {2,4,6}.
- Result after an accepted move:
  - Mover's board contains a full line: 100 for X, 010 for O.
  - Otherwise, all 9 cells occupied: 001.
  - Otherwise: 000.
  - A win completed on the 9th move reports the win, not a draw.
- Once `vencedor` ≠ 000 the game is frozen until reset.

## Timing
- Single-cycle latency: a move sampled at edge N is visible in the board and in `vencedor` after edge N.
- `vencedor` is a register output with no combinational path from `posicao`.
- At most one move per cycle.
- Reset asserted mid-game or after a result: state is cleared at the next edge; `vencedor` = 000 from that edge on.

## Structure
- Shared package `tictactoe_pkg`:
  - Localparam array of the 8 nine-bit win-line masks.
  - Result encodings `RES_NONE`=000, `RES_X`=100, `RES_O`=010, `RES_DRAW`=001.
  - Board width constant 9.
- One sub-module `win_detect`: combinational, takes `board[0:8]` and returns `has_line`. Two instances evaluate the next-state X and O boards.
- One-hot check and the draw condition (`&(board_x|board_o)`) stay in the top level.

## Test plan
- Reset held 3 cycles while `posicao`=100000000 → `vencedor`=000 and board empty afterwards; the first post-reset move is X's.
- X top-row win, moves applied one per cycle:
  - X 100000000, O 000100000, X 010000000, O 000010000, X 001000000.
  - `vencedor`=100 after the 5th edge and 000 before it.
- O anti-diagonal win, moves applied one per cycle:
  - X 100000000, O 001000000, X 010000000, O 000010000, X 000000001, O 000000100.
  - `vencedor`=010 after the 6th edge.
- Rejections: after X at 100000000, each of these leaves the board unchanged and O still to move:
  - Apply 100000000 again.
  - Apply 110000000 (multi-hot).
  - Apply 000000000.
  - The next O move at 000000001 is then accepted.
- Draw, moves in order X0, O1, X2, O4, X3, O5, X7, O6, X8 → `vencedor`=001 after the 9th edge.
- Freeze and reset:
  - After an X win, apply `posicao`=000000010 → no change, `vencedor` stays 100.
  - Then assert `reset` for 1 cycle → `vencedor`=000, board empty, X to move.
